// File: rtl/stopwatch_pkg.sv
// Shared types and default sizing for the stopwatch control slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam int unsigned TICK_DIV_DEF = 500000;  // 50 MHz -> 100 Hz
    localparam int unsigned CS_N_DEF     = 100;
    localparam int unsigned SEC_N_DEF    = 60;
    localparam int unsigned MIN_N_DEF    = 60;

    // Bits needed to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/upcount.sv
// Modulo-N up counter with synchronous reset and count enable.
// Ports:
//   clk       - clock, posedge
//   sreset    - synchronous active-high reset to zero
//   i_enable  - advance by one on the next edge (wraps N-1 -> 0)
//   o_val     - current count
//   o_last    - 1 while o_val == N-1
module upcount
    import stopwatch_pkg::*;
#(
    parameter  int unsigned N = 10,
    localparam int unsigned W = cnt_w(N)
) (
    input  logic         clk,
    input  logic         sreset,
    input  logic         i_enable,
    output logic [W-1:0] o_val,
    output logic         o_last
);

    assign o_last = (o_val == W'(N - 1));

    // Count register
    always_ff @(posedge clk) begin
        if (sreset) begin
            o_val <= '0;
        end else if (i_enable) begin
            o_val <= o_last ? '0 : o_val + W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/pause/clear FSM, prescaled enable cascade into the
// centisecond/second/minute counters, lap freeze latch and wrap pulse.
// Ports:
//   clk, sreset     - clock and synchronous active-high reset
//   i_start_stop    - pulse, toggles run/pause
//   i_clear         - pulse, zeroes counts (ignored while running)
//   i_lap           - pulse, toggles lap freeze (running only)
//   o_cs/o_sec/o_min- displayed time (latched lap or live counts)
//   o_running       - 1 in RUN
//   o_lap_active    - 1 while display is frozen
//   o_rollover      - one-cycle pulse in the first cycle after a full wrap
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter  int unsigned TICK_DIV = TICK_DIV_DEF,
    parameter  int unsigned CS_N     = CS_N_DEF,
    parameter  int unsigned SEC_N    = SEC_N_DEF,
    parameter  int unsigned MIN_N    = MIN_N_DEF,
    localparam int unsigned CS_W     = cnt_w(CS_N),
    localparam int unsigned SEC_W    = cnt_w(SEC_N),
    localparam int unsigned MIN_W    = cnt_w(MIN_N),
    localparam int unsigned PRE_W    = cnt_w(TICK_DIV)
) (
    input  logic             clk,
    input  logic             sreset,
    input  logic             i_start_stop,
    input  logic             i_clear,
    input  logic             i_lap,
    output logic [CS_W-1:0]  o_cs,
    output logic [SEC_W-1:0] o_sec,
    output logic [MIN_W-1:0] o_min,
    output logic             o_running,
    output logic             o_lap_active,
    output logic             o_rollover
);

    sw_state_t state_q;
    sw_state_t state_d;

    logic running;
    logic clear_fire;
    logic lap_fire;
    logic tick;
    logic cs_en;
    logic sec_en;
    logic min_en;
    logic wrap;
    logic cnt_rst;

    logic [PRE_W-1:0] pre_val;
    logic             pre_last;
    logic [CS_W-1:0]  cs_val;
    logic             cs_last;
    logic [SEC_W-1:0] sec_val;
    logic             sec_last;
    logic [MIN_W-1:0] min_val;
    logic             min_last;

    logic [CS_W-1:0]  lap_cs_q;
    logic [SEC_W-1:0] lap_sec_q;
    logic [MIN_W-1:0] lap_min_q;
    logic             lap_active_q;
    logic             rollover_q;

    // Prescaler phase is internal; only its terminal flag is consumed.
    logic unused_pre_val;
    assign unused_pre_val = ^pre_val;

    // State register
    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear beats start_stop when stopped, start_stop beats clear when running
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_clear)           state_d = IDLE;
                else if (i_start_stop) state_d = RUN;
            end
            RUN: begin
                if (i_start_stop)      state_d = PAUSE;
            end
            PAUSE: begin
                if (i_clear)           state_d = IDLE;
                else if (i_start_stop) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // State decode: accepted pulses and the enable cascade
    always_comb begin
        running    = 1'b0;
        clear_fire = 1'b0;
        lap_fire   = 1'b0;
        tick       = 1'b0;
        cs_en      = 1'b0;
        sec_en     = 1'b0;
        min_en     = 1'b0;
        wrap       = 1'b0;

        running    = (state_q == RUN);
        clear_fire = i_clear & ~running;
        lap_fire   = i_lap & ~i_start_stop & running;
        // Gate with running so a prescaler parked at its last value cannot tick in PAUSE.
        tick       = running & pre_last;
        cs_en      = tick;
        sec_en     = tick & cs_last;
        min_en     = sec_en & sec_last;
        wrap       = min_en & min_last;
    end

    assign cnt_rst = sreset | clear_fire;

    upcount #(.N(TICK_DIV)) u_prescaler (
        .clk      (clk),
        .sreset   (cnt_rst),
        .i_enable (running),
        .o_val    (pre_val),
        .o_last   (pre_last)
    );

    upcount #(.N(CS_N)) u_cs (
        .clk      (clk),
        .sreset   (cnt_rst),
        .i_enable (cs_en),
        .o_val    (cs_val),
        .o_last   (cs_last)
    );

    upcount #(.N(SEC_N)) u_sec (
        .clk      (clk),
        .sreset   (cnt_rst),
        .i_enable (sec_en),
        .o_val    (sec_val),
        .o_last   (sec_last)
    );

    upcount #(.N(MIN_N)) u_min (
        .clk      (clk),
        .sreset   (cnt_rst),
        .i_enable (min_en),
        .o_val    (min_val),
        .o_last   (min_last)
    );

    // Lap latch captures the pre-edge live counts; rollover marks the all-zero cycle
    always_ff @(posedge clk) begin
        if (sreset) begin
            lap_cs_q     <= '0;
            lap_sec_q    <= '0;
            lap_min_q    <= '0;
            lap_active_q <= 1'b0;
            rollover_q   <= 1'b0;
        end else begin
            rollover_q <= wrap;
            if (clear_fire) begin
                lap_active_q <= 1'b0;
            end else if (lap_fire) begin
                if (!lap_active_q) begin
                    lap_cs_q     <= cs_val;
                    lap_sec_q    <= sec_val;
                    lap_min_q    <= min_val;
                    lap_active_q <= 1'b1;
                end else begin
                    lap_active_q <= 1'b0;
                end
            end
        end
    end

    assign o_running    = running;
    assign o_lap_active = lap_active_q;
    assign o_rollover   = rollover_q;
    assign o_cs         = lap_active_q ? lap_cs_q  : cs_val;
    assign o_sec        = lap_active_q ? lap_sec_q : sec_val;
    assign o_min        = lap_active_q ? lap_min_q : min_val;

endmodule
